// File: rtl/seg_pkg.sv
// seg_pkg: segment width, bit positions and hex glyph table for the scan driver.
package seg_pkg;
  localparam int SEG_W = 8;
  localparam int SEG_A = 7;
  localparam int SEG_G = 1;
  localparam int SEG_DP = 0;
  localparam logic [6:0] GLYPH [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    return GLYPH[nib];
  endfunction
endpackage

// File: rtl/seg_hex_font.sv
// seg_hex_font: nibble plus decimal point to {a,b,c,d,e,f,g,dp} pattern.
module seg_hex_font
  import seg_pkg::*;
(
  input  logic [3:0]       nib,
  input  logic             dp,
  output logic [SEG_W-1:0] pat
);
  always_comb begin
    pat = '0;
    pat[SEG_A:SEG_G] = hex_glyph(nib);
    pat[SEG_DP] = dp;
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: double-buffered N-digit hex seven-segment scanner.
// Define SEG_SCAN_BLINK_EN to build the per-digit blink logic.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int CLK_DIV = 1000,
  parameter int ACTIVE_LOW = 0,
  parameter int BLINK_DIV = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic                    value_valid,
  output logic                    value_ready,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [SEG_W-1:0]        seg_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_end
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(CLK_DIV);
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [SEG_W-1:0] SEG_OFF = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = (ACTIVE_LOW != 0) ? '1 : '0;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic pend_q, pend_d, fe_q, fe_d;
  logic [VW-1:0] pend_val_q, pend_val_d, disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d, lz;
  logic [SEG_W-1:0] seg_q, seg_d, font_pat;
  logic tick, wrap, take, commit, lz_run, blink_blank, blank;
  assign tick = cnt_q == CW'(CLK_DIV - 1);
  assign wrap = tick && idx_q == IW'(NUM_DIGITS - 1);
  assign take = value_valid && !pend_q;
  assign commit = wrap && pend_q;
  assign value_ready = !pend_q;
  assign seg_out = seg_q;
  assign digit_sel = sel_q;
  assign frame_end = fe_q;
  seg_hex_font u_font (
    .nib(disp_val_q[4*idx_q +: 4]),
    .dp (disp_dp_q[idx_q]),
    .pat(font_pat)
  );
  // A digit is leading-zero blank when it and every digit above it are zero.
  always_comb begin
    lz = '0;
    lz_run = lz_en;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lz_run = lz_run & (disp_val_q[4*i +: 4] == 4'h0);
      lz[i] = lz_run & (i != 0);
    end
  end
`ifdef SEG_SCAN_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV + 1);
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic phase_q, phase_d;
  always_comb begin
    blink_cnt_d = !wrap ? blink_cnt_q : (blink_cnt_q == BW'(BLINK_DIV - 1)) ? '0 : blink_cnt_q + 1'b1;
    phase_d = (wrap && blink_cnt_q == BW'(BLINK_DIV - 1)) ? !phase_q : phase_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      blink_cnt_q <= '0;
      phase_q <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q <= phase_d;
    end
  assign blink_blank = phase_q & blink_mask[idx_q];
`else
  logic unused_blink;
  assign unused_blink = ^blink_mask;
  assign blink_blank = 1'b0;
`endif
  assign blank = blank_mask[idx_q] | lz[idx_q] | blink_blank;
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    idx_d = !tick ? idx_q : wrap ? '0 : idx_q + 1'b1;
    pend_d = take | (pend_q & !commit);
    pend_val_d = take ? value_i : pend_val_q;
    pend_dp_d = take ? dp_i : pend_dp_q;
    disp_val_d = commit ? pend_val_q : disp_val_q;
    disp_dp_d = commit ? pend_dp_q : disp_dp_q;
    fe_d = wrap;
    seg_d = (blank ? '0 : font_pat) ^ SEG_OFF;
    sel_d = (NUM_DIGITS'(1) << idx_q) ^ SEL_OFF;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      pend_q <= 1'b0;
      pend_val_q <= '0;
      pend_dp_q <= '0;
      disp_val_q <= '0;
      disp_dp_q <= '0;
      fe_q <= 1'b0;
      seg_q <= SEG_OFF;
      sel_q <= SEL_OFF;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      pend_q <= pend_d;
      pend_val_q <= pend_val_d;
      pend_dp_q <= pend_dp_d;
      disp_val_q <= disp_val_d;
      disp_dp_q <= disp_dp_d;
      fe_q <= fe_d;
      seg_q <= seg_d;
      sel_q <= sel_d;
    end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Parametrised, time-multiplexed N-digit hex seven-segment display driver.
- Accepts a packed hex value through a valid/ready handshake and double-buffers it so updates land only at frame boundaries (tear-free).
- Scans one digit at a time, with decimal-point control, per-digit blanking and leading-zero suppression.
- Sits between CPU-side debug/status registers and the board segment/anode pins.

Parameters:
- NUM_DIGITS, 8, number of digits scanned; must be ≥2.
- CLK_DIV, 1000, clk cycles each digit is held; must be ≥2.
- ACTIVE_LOW, 0, 1 inverts seg_out and digit_sel at the output register.
- BLINK_DIV, 32, frames per blink phase toggle (used only with SEG_SCAN_BLINK_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- value_i  in  4*NUM_DIGITS  packed nibbles; [3:0] is digit 0 (rightmost).
- value_valid  in  1  value_i/dp_i offered.
- value_ready  out  1  high when no update is pending.
- dp_i  in  NUM_DIGITS  decimal-point enables, latched with value_i.
- blank_mask  in  NUM_DIGITS  live per-digit force-blank.
- lz_en  in  1  live leading-zero blanking enable.
- blink_mask  in  NUM_DIGITS  live per-digit blink enables.
- seg_out  out  8  {a,b,c,d,e,f,g,dp}, active-high unless ACTIVE_LOW.
- digit_sel  out  NUM_DIGITS  one-hot digit enable, active-high unless ACTIVE_LOW.
- frame_end  out  1  one-cycle pulse on each scan wrap.

Behaviour:
- Reset (async, all state):
  - Prescaler, digit index, display buffer, pending buffer, pending flag and blink phase all 0.
  - seg_out and digit_sel at inactive level (all 0, or all 1 if ACTIVE_LOW).
  - frame_end=0; value_ready=1 after reset.
- Prescaler:
  - Counts 0..CLK_DIV-1; tick asserted at CLK_DIV-1, then count wraps to 0.
- Digit index:
  - Advances on tick; wraps NUM_DIGITS-1 → 0.
  - The wrap tick is the frame boundary; frame_end is registered and high in the cycle after it.
- Handshake:
  - value_ready = !pending (registered flag).
  - On value_valid && value_ready: value_i and dp_i are captured into the pending buffer and pending is set.
  - value_valid while value_ready=0 is ignored; the source must hold value_valid.
- Commit:
  - At the frame boundary with pending=1: display buffer ← pending buffer; pending cleared.
  - value_ready rises the next cycle. No capture occurs in the commit cycle.
- Glyph table (abcdefg):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
  - dp bit = latched dp_i[idx].
- Leading-zero blanking:
  - When lz_en=1, a digit is blanked if it and every higher digit hold nibble 0.
  - Digit 0 is never lz-blanked.
- Blank rule: blank = blank_mask[idx] | lz-blank | blink-blank. A blanked digit drives all segments off, including dp; digit_sel is still driven.
- Output register:
  - seg_out and digit_sel are registered, one cycle after the index change.
  - Inversion by ACTIVE_LOW is applied at this register.
  - blank_mask, lz_en and blink_mask are sampled live; they are not buffered.

Optional Feature:
- Macro: SEG_SCAN_BLINK_EN.
- Defined:
  - A frame counter toggles blink phase every BLINK_DIV frame boundaries.
  - When phase=1, digits with blink_mask set are blanked.
  - The blink counter and phase reset to 0.
- Undefined:
  - No blink counter logic is generated.
  - The blink_mask port remains but is ignored.
  - BLINK_DIV has no effect.

Decomposition:
- Package seg_pkg:
  - SEG_W=8 constant.
  - Hex-to-abcdefg glyph function/constant table.
  - Segment bit-position constants.
- Sub-module seg_hex_font: combinational nibble+dp → 8-bit pattern using the seg_pkg table.
- Prescaler, scan index, double buffer, blanking and output register stay in seg_scan_ctrl.

Test Plan:
All scenarios use NUM_DIGITS=4, CLK_DIV=4, ACTIVE_LOW=0.
- Reset release, idle: seg_out=8'h00 and digit_sel=4'b0000 during reset. Afterwards digit_sel cycles 0001→0010→0100→1000 every 4 clks; frame_end pulses every 16 clks.
- Load value_i=16'h12AF, dp_i=4'b0001 mid-frame:
  - Nothing changes until the next frame boundary; value_ready=0 until the commit.
  - Then digit 0 shows F with dp (8'h8F), digit 1 A (8'hEE), digit 2 2 (8'hDA), digit 3 1 (8'h60).
- Back-to-back offers: second value_valid held during pending is not accepted; it is captured the cycle after commit and shows one frame later.
- lz_en=1 with value 16'h0005: digits 3..1 output 8'h00, digit 0 shows 8'hB6. With value 16'h0000, digit 0 shows 8'hFC.
- ACTIVE_LOW=1 rerun of the 16'h12AF load: seg_out and digit_sel are bitwise inverted (digit 0 select = 4'b1110, seg 8'h70). Assert rst mid-frame: all state and outputs are immediately at inactive levels.
- SEG_SCAN_BLINK_EN with BLINK_DIV=2, blink_mask=4'b0010: digit 1 is blanked for frames 2–3, shown for frames 4–5, and so on. Other digits are unaffected.
